// File: rtl/fir_tb_pkg.sv
// Shared types for the parallel-FIR stimulus/index generators.
package fir_tb_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} idxgen_state_t;
    typedef enum logic       {WRAP, ONESHOT}   idxgen_mode_t;

    // Extra compare bits so base+LANES never overflows, even for tiny WIDTH.
    localparam int unsigned CMP_HEADROOM = 4;

endpackage

// File: rtl/idx_base_counter.sv
// Base-index register: steps by LANES per advance, detects the final group of a
// pass and either wraps to zero or holds there.
module idx_base_counter
    import fir_tb_pkg::*;
#(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned LANES = 2
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             clear_i,
    input  logic             advance_i,
    input  logic             wrap_i,
    input  logic             active_i,
    input  logic [WIDTH-1:0] limit_i,
    output logic [WIDTH-1:0] base_o,
    output logic             last_o
);

    localparam int unsigned CW = WIDTH + CMP_HEADROOM;

    logic [WIDTH-1:0] base_q, base_d;
    logic [CW-1:0]    next_ext;
    logic             reach;

    // Next base: clear wins, then step, wrap or hold on the final group.
    always_comb begin
        next_ext = CW'(base_q) + CW'(LANES);
        reach    = (next_ext >= CW'(limit_i));
        base_d   = base_q;
        if (clear_i) begin
            base_d = '0;
        end else if (advance_i) begin
            if (!reach) begin
                base_d = next_ext[WIDTH-1:0];
            end else if (wrap_i) begin
                base_d = '0;
            end
        end
    end

    // Base register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            base_q <= '0;
        end else begin
            base_q <= base_d;
        end
    end

    assign base_o = base_q;
    assign last_o = active_i & reach;

endmodule

// File: rtl/sample_index_gen.sv
// Multi-lane sample-index generator: LANES consecutive indices per clock with
// programmable limit, wrap/one-shot mode, stall, lane-valid mask and epoch count.
module sample_index_gen
    import fir_tb_pkg::*;
#(
    parameter int unsigned WIDTH   = 9,
    parameter int unsigned LANES   = 2,
    parameter int unsigned EPOCH_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   en,
    input  logic                   mode,
    input  logic [WIDTH-1:0]       limit,
    output logic [LANES*WIDTH-1:0] idx,
    output logic [LANES-1:0]       lane_valid,
    output logic                   valid,
    output logic                   last,
    output logic                   wrap_pulse,
    output logic                   done,
    output logic [EPOCH_W-1:0]     epoch
);

    localparam int unsigned CW = WIDTH + CMP_HEADROOM;

    idxgen_state_t    state_q;
    idxgen_mode_t     mode_q;
    logic [WIDTH-1:0] limit_q;
    logic [EPOCH_W-1:0] epoch_q;
    logic             wrap_pulse_q;

    logic             start_ok;
    logic             advance;
    logic [WIDTH-1:0] base;
    logic             last_w;
    logic [CW-1:0]    lane_ext;

    // A start with a zero limit is ignored entirely; start beats en.
    assign start_ok = start & (limit != '0);
    assign valid    = (state_q == RUN);
    assign advance  = valid & en & ~start_ok;

    idx_base_counter #(
        .WIDTH (WIDTH),
        .LANES (LANES)
    ) u_base (
        .clk_i     (clk),
        .reset_i   (reset),
        .clear_i   (start_ok),
        .advance_i (advance),
        .wrap_i    (mode_q == WRAP),
        .active_i  (valid),
        .limit_i   (limit_q),
        .base_o    (base),
        .last_o    (last_w)
    );

    // Control FSM, latched configuration, epoch counter and wrap pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            mode_q       <= WRAP;
            limit_q      <= '0;
            epoch_q      <= '0;
            wrap_pulse_q <= 1'b0;
        end else begin
            wrap_pulse_q <= 1'b0;
            if (start_ok) begin
                state_q <= RUN;
                mode_q  <= idxgen_mode_t'(mode);
                limit_q <= limit;
                epoch_q <= '0;
            end else if (advance && last_w) begin
                wrap_pulse_q <= 1'b1;
                if (epoch_q != '1) begin
                    epoch_q <= epoch_q + 1'b1;
                end
                if (mode_q == ONESHOT) begin
                    state_q <= DONE;
                end
            end
        end
    end

    // Lane expansion; idx is forced to zero whenever not running.
    always_comb begin
        idx        = '0;
        lane_valid = '0;
        lane_ext   = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            lane_ext = CW'(base) + CW'(k);
            if (valid) begin
                idx[k*WIDTH +: WIDTH] = lane_ext[WIDTH-1:0];
            end
            lane_valid[k] = valid & (lane_ext < CW'(limit_q));
        end
    end

    assign last       = last_w;
    assign wrap_pulse = wrap_pulse_q;
    assign done       = (state_q == DONE);
    assign epoch      = epoch_q;

endmodule

// File: tb/tb_sample_index_gen.sv
// Self-checking bench for sample_index_gen against a group-counting reference model.
module tb_sample_index_gen;

    localparam int W  = 9;
    localparam int L  = 2;
    localparam int E  = 8;
    localparam int W2 = 4;
    localparam int L2 = 3;
    localparam int E2 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT (WIDTH=9, LANES=2)
    logic           reset, start, en, mode;
    logic [W-1:0]   limit;
    logic [L*W-1:0] idx;
    logic [L-1:0]   lane_valid;
    logic           valid, last, wrap_pulse, done;
    logic [E-1:0]   epoch;

    sample_index_gen #(.WIDTH(W), .LANES(L), .EPOCH_W(E)) dut (
        .clk(clk), .reset(reset), .start(start), .en(en), .mode(mode), .limit(limit),
        .idx(idx), .lane_valid(lane_valid), .valid(valid), .last(last),
        .wrap_pulse(wrap_pulse), .done(done), .epoch(epoch)
    );

    // Small DUT (WIDTH=4, LANES=3, EPOCH_W=3)
    logic             reset2, start2, en2, mode2;
    logic [W2-1:0]    limit2;
    logic [L2*W2-1:0] idx2;
    logic [L2-1:0]    lane_valid2;
    logic             valid2, last2, wrap_pulse2, done2;
    logic [E2-1:0]    epoch2;

    sample_index_gen #(.WIDTH(W2), .LANES(L2), .EPOCH_W(E2)) dut2 (
        .clk(clk), .reset(reset2), .start(start2), .en(en2), .mode(mode2), .limit(limit2),
        .idx(idx2), .lane_valid(lane_valid2), .valid(valid2), .last(last2),
        .wrap_pulse(wrap_pulse2), .done(done2), .epoch(epoch2)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: a pass is ceil(lim/L) groups; group g covers g*L .. g*L+L-1.
    bit m_run, m_done, m_one, m_pulse;
    int m_lim, m_g, m_epoch;

    function automatic int ngroups();
        return (m_lim + L - 1) / L;
    endfunction

    task automatic model_step();
        bit p;
        p = 1'b0;
        if (reset) begin
            m_run = 0; m_done = 0; m_one = 0; m_lim = 0; m_g = 0; m_epoch = 0;
        end else begin
            if (start && limit != 0) begin
                m_run = 1; m_done = 0; m_lim = int'(limit); m_one = mode; m_g = 0; m_epoch = 0;
            end else if (m_run && en) begin
                if (m_g == ngroups() - 1) begin
                    p = 1'b1;
                    if (m_epoch < (1 << E) - 1) m_epoch++;
                    if (m_one) begin
                        m_run = 0; m_done = 1;
                    end else begin
                        m_g = 0;
                    end
                end else begin
                    m_g++;
                end
            end
        end
        m_pulse = p;
    endtask

    task automatic compare_all();
        logic [L-1:0] lv_e;
        lv_e = '0;
        for (int k = 0; k < L; k++) lv_e[k] = m_run && (m_g * L + k < m_lim);
        check("valid", valid, m_run);
        check("done", done, m_done);
        check("wrap_pulse", wrap_pulse, m_pulse);
        check("epoch", epoch, m_epoch);
        check("last", last, m_run && (m_g == ngroups() - 1));
        check("lane_valid", lane_valid, lv_e);
        if (!m_run) begin
            check("idx_not_running", idx, 0);
        end else begin
            for (int k = 0; k < L; k++)
                if (lv_e[k]) check("idx_lane", idx[k*W +: W], (m_g * L + k) % (1 << W));
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    initial begin
        reset = 1; start = 0; en = 0; mode = 0; limit = '0;
        reset2 = 1; start2 = 0; en2 = 0; mode2 = 0; limit2 = '0;
        repeat (2) @(posedge clk);
        #1;

        // Small DUT: limit 15, LANES=3 -> last group (12,13,14) fully valid, epoch saturates at 7.
        reset2 = 0; start2 = 1; limit2 = 4'd15; mode2 = 0; en2 = 1;
        @(posedge clk); #1;
        start2 = 0;
        for (int p = 0; p < 9; p++) begin
            for (int g = 0; g < 5; g++) begin
                check("w4_lane_valid", lane_valid2, 3'b111);
                check("w4_last", last2, g == 4);
                check("w4_epoch", epoch2, (p > 7) ? 7 : p);
                check("w4_wrap_pulse", wrap_pulse2, (g == 0) && (p > 0));
                for (int k = 0; k < L2; k++) check("w4_idx", idx2[k*W2 +: W2], 3 * g + k);
                @(posedge clk); #1;
            end
        end

        // Reset state of the main DUT.
        cyc();
        check("rst_idx", idx, 0);
        reset = 0;
        cyc();

        // WRAP, limit 470: 235 groups per pass.
        start = 1; limit = 9'd470; mode = 0; en = 1;
        cyc();
        start = 0;
        for (int i = 0; i < 470; i++) begin
            cyc();
            if (i == 233) begin
                check("t1_last", last, 1);
                check("t1_last_lo", idx[0 +: W], 468);
                check("t1_last_hi", idx[W +: W], 469);
            end
            if (i == 234) begin
                check("t1_epoch1", epoch, 1);
                check("t1_wrap_base", idx[0 +: W], 0);
                check("t1_pulse", wrap_pulse, 1);
            end
            if (i == 235) check("t1_pulse_once", wrap_pulse, 0);
        end
        check("t1_epoch2", epoch, 2);

        // ONESHOT, limit 5: lane_valid 11,11,01 then done.
        start = 1; limit = 9'd5; mode = 1;
        cyc();
        start = 0;
        check("t2_lv0", lane_valid, 2'b11);
        cyc();
        check("t2_lv1", lane_valid, 2'b11);
        cyc();
        check("t2_lv2", lane_valid, 2'b01);
        check("t2_idx4", idx[0 +: W], 4);
        cyc();
        check("t2_done", done, 1);
        check("t2_epoch", epoch, 1);
        for (int i = 0; i < 10; i++) begin
            en = 1'($urandom_range(0, 1));
            limit = 9'($urandom_range(0, 511));
            cyc();
            check("t2_done_hold", done, 1);
        end

        // Stall from base 4.
        start = 1; limit = 9'd20; mode = 0; en = 1;
        cyc();
        start = 0;
        cyc();
        cyc();
        check("t3_base4", idx[0 +: W], 4);
        en = 0;
        repeat (2) begin
            cyc();
            check("t3_hold_lo", idx[0 +: W], 4);
            check("t3_hold_hi", idx[W +: W], 5);
            check("t3_no_pulse", wrap_pulse, 0);
        end
        en = 1;
        cyc();
        check("t3_adv_lo", idx[0 +: W], 6);
        check("t3_adv_hi", idx[W +: W], 7);

        // Restart mid-run at base 100 with limit 10.
        start = 1; limit = 9'd400; mode = 0; en = 1;
        cyc();
        start = 0;
        repeat (50) cyc();
        check("t4_base100", idx[0 +: W], 100);
        start = 1; limit = 9'd10;
        cyc();
        start = 0; limit = 9'd300;
        check("t4_restart_base", idx[0 +: W], 0);
        check("t4_restart_epoch", epoch, 0);
        repeat (5) cyc();
        check("t4_limit10_wrap", epoch, 1);

        // Reset mid-run at base 200.
        start = 1; limit = 9'd400;
        cyc();
        start = 0;
        repeat (100) cyc();
        check("t5_base200", idx[0 +: W], 200);
        reset = 1;
        cyc();
        reset = 0;
        check("t5_valid", valid, 0);
        check("t5_idx", idx, 0);
        start = 1; limit = '0;
        cyc();
        start = 0;
        cyc();
        check("t5_zero_limit_idle", valid, 0);

        // Randomized traffic, including max limit and mid-run limit changes.
        for (int i = 0; i < 4000; i++) begin
            reset = ($urandom_range(0, 299) == 0);
            start = ($urandom_range(0, 39) == 0);
            case ($urandom_range(0, 5))
                0:       limit = 9'd511;
                1:       limit = 9'($urandom_range(0, 511));
                default: limit = 9'($urandom_range(0, 12));
            endcase
            en   = ($urandom_range(0, 3) != 0);
            mode = 1'($urandom_range(0, 1));
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
